// File: rtl/heap_pkg.sv
// Shared types and key ordering for heap_ctrl.
// Define HEAP_CTRL_MAXHEAP_EN to build a max-heap; the default build is a min-heap.
package heap_pkg;

  localparam int unsigned KEY_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    UP_RD,
    UP_WR,
    RM_LAST,
    DN_RDL,
    DN_RDR,
    DN_CMP
  } heap_state_e;

  // True when key a must sit above key b; strict, so equal keys never swap.
  function automatic logic key_before(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
`ifdef HEAP_CTRL_MAXHEAP_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

endpackage

// File: rtl/mem256x8.sv
// 256x8 storage for heap_ctrl: combinational read, write commits on the clock edge.
module mem256x8 (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic       wen,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] mem_q [256];

  always_ff @(posedge clk) begin
    if (wen) mem_q[addr] <= din;
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/heap_ctrl.sv
// Binary heap controller over an external single-port memory, one access per cycle.
// Ordering is min-heap by default, max-heap when HEAP_CTRL_MAXHEAP_EN is defined.
module heap_ctrl
  import heap_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_req,
  input  logic [KEY_W-1:0]  ins_data,
  input  logic              rem_req,
  output logic              ready,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] count,
  output logic [KEY_W-1:0]  top_data,
  output logic              rem_valid,
  output logic [KEY_W-1:0]  rem_data,
  output logic              ovf,
  output logic              udf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [KEY_W-1:0]  mem_din,
  input  logic [KEY_W-1:0]  mem_dout
);

  localparam int unsigned LW = ADDR_W + 1;

  heap_state_e       state_q;
  logic [ADDR_W-1:0] count_q, idx_q, ci_q;
  logic [KEY_W-1:0]  val_q, p_q, c_q, rem_data_q;
  logic              phase_q, rem_valid_q, ovf_q, udf_q;

  logic [LW-1:0] l_c, l1_c, cnt_w_c;
  logic          full_c;

  assign l_c     = {idx_q, 1'b0};
  assign l1_c    = l_c + LW'(1);
  assign cnt_w_c = {1'b0, count_q};
  assign full_c  = (count_q == {ADDR_W{1'b1}});

  // Memory port decode: address/write are a pure function of the registered state.
  always_comb begin
    mem_addr = ADDR_W'(1);
    mem_wen  = 1'b0;
    mem_din  = val_q;
    case (state_q)
      UP_RD: begin
        if (idx_q == ADDR_W'(1) || phase_q) begin
          mem_addr = idx_q;
          mem_wen  = 1'b1;
        end else begin
          mem_addr = idx_q >> 1;
        end
      end
      UP_WR: begin
        mem_addr = idx_q;
        mem_wen  = 1'b1;
        mem_din  = p_q;
      end
      RM_LAST: mem_addr = count_q;
      DN_RDL: begin
        if (l_c > cnt_w_c) begin
          mem_addr = idx_q;
          mem_wen  = 1'b1;
        end else begin
          mem_addr = l_c[ADDR_W-1:0];
        end
      end
      DN_RDR: if (l1_c <= cnt_w_c) mem_addr = l1_c[ADDR_W-1:0];
      DN_CMP: begin
        mem_addr = idx_q;
        mem_wen  = 1'b1;
        mem_din  = key_before(c_q, val_q) ? c_q : val_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      ci_q        <= '0;
      val_q       <= '0;
      p_q         <= '0;
      c_q         <= '0;
      phase_q     <= 1'b0;
      rem_data_q  <= '0;
      rem_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      rem_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rem_req) begin
            if (count_q == '0) begin
              udf_q <= 1'b1;
            end else begin
              rem_data_q  <= mem_dout;
              rem_valid_q <= 1'b1;
              state_q     <= RM_LAST;
            end
          end else if (ins_req) begin
            if (full_c) begin
              ovf_q <= 1'b1;
            end else begin
              val_q   <= ins_data;
              idx_q   <= count_q + ADDR_W'(1);
              count_q <= count_q + ADDR_W'(1);
              phase_q <= 1'b0;
              state_q <= UP_RD;
            end
          end
        end
        // Phase 0 reads the parent; phase 1 writes val once no swap is needed.
        UP_RD: begin
          if (idx_q == ADDR_W'(1) || phase_q) begin
            state_q <= IDLE;
          end else if (key_before(val_q, mem_dout)) begin
            p_q     <= mem_dout;
            state_q <= UP_WR;
          end else begin
            phase_q <= 1'b1;
          end
        end
        UP_WR: begin
          idx_q   <= idx_q >> 1;
          phase_q <= 1'b0;
          state_q <= UP_RD;
        end
        RM_LAST: begin
          val_q   <= mem_dout;
          count_q <= count_q - ADDR_W'(1);
          idx_q   <= ADDR_W'(1);
          state_q <= (count_q == ADDR_W'(1)) ? IDLE : DN_RDL;
        end
        DN_RDL: begin
          if (l_c > cnt_w_c) begin
            state_q <= IDLE;
          end else begin
            c_q     <= mem_dout;
            ci_q    <= l_c[ADDR_W-1:0];
            state_q <= DN_RDR;
          end
        end
        DN_RDR: begin
          if (l1_c <= cnt_w_c && key_before(mem_dout, c_q)) begin
            c_q  <= mem_dout;
            ci_q <= l1_c[ADDR_W-1:0];
          end
          state_q <= DN_CMP;
        end
        DN_CMP: begin
          if (key_before(c_q, val_q)) begin
            idx_q   <= ci_q;
            state_q <= DN_RDL;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign empty     = (count_q == '0);
  assign full      = full_c;
  assign count     = count_q;
  assign top_data  = mem_dout;
  assign rem_valid = rem_valid_q;
  assign rem_data  = rem_data_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_heap_ctrl.sv
// Directed self-checking bench for heap_ctrl (default min-heap build) on a mem256x8.
module tb_heap_ctrl;

  logic       clk = 1'b0;
  logic       reset, ins_req, rem_req;
  logic [7:0] ins_data;
  logic       ready, empty, full, rem_valid, ovf, udf, mem_wen;
  logic [7:0] count, top_data, rem_data, mem_addr, mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] got;

  heap_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .ins_req(ins_req), .ins_data(ins_data), .rem_req(rem_req),
    .ready(ready), .empty(empty), .full(full), .count(count), .top_data(top_data),
    .rem_valid(rem_valid), .rem_data(rem_data), .ovf(ovf), .udf(udf),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem256x8 u_mem (.clk(clk), .addr(mem_addr), .wen(mem_wen), .din(mem_din), .dout(mem_dout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", 32'(ready), 1);
  endtask

  task automatic do_insert(input logic [7:0] k);
    ins_req  = 1'b1;
    ins_data = k;
    tick();
    ins_req = 1'b0;
    wait_ready();
  endtask

  task automatic do_remove(output logic [7:0] k);
    rem_req = 1'b1;
    tick();
    rem_req = 1'b0;
    chk("rem_valid_pulse", 32'(rem_valid), 1);
    k = rem_data;
    wait_ready();
  endtask

  initial begin
    reset = 1'b1; ins_req = 1'b0; rem_req = 1'b0; ins_data = 8'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rem_valid", 32'(rem_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    chk("rst_rem_data", 32'(rem_data), 0);

    // Remove on empty heap raises udf only.
    rem_req = 1'b1; tick(); rem_req = 1'b0;
    chk("udf_pulse", 32'(udf), 1);
    chk("udf_ready", 32'(ready), 1);
    tick();
    chk("udf_clear", 32'(udf), 0);

    do_insert(8'd5); do_insert(8'd3); do_insert(8'd8); do_insert(8'd1);
    chk("ins4_top", 32'(top_data), 1);
    chk("ins4_count", 32'(count), 4);

    do_remove(got); chk("rm_1", 32'(got), 1);
    do_remove(got); chk("rm_3", 32'(got), 3);
    do_remove(got); chk("rm_5", 32'(got), 5);
    do_remove(got); chk("rm_8", 32'(got), 8);
    chk("rm_empty", 32'(empty), 1);

    // Insert into empty heap: a single busy cycle.
    ins_req = 1'b1; ins_data = 8'd7;
    tick();
    ins_req = 1'b0;
    chk("ins7_busy", 32'(ready), 0);
    tick();
    chk("ins7_ready", 32'(ready), 1);
    chk("ins7_top", 32'(top_data), 7);
    chk("ins7_count", 32'(count), 1);
    do_remove(got); chk("rm_7", 32'(got), 7);

    // Fill with 255 descending keys, then overflow.
    for (int k = 255; k >= 1; k--) do_insert(8'(k));
    chk("fill_count", 32'(count), 255);
    chk("fill_full", 32'(full), 1);
    chk("fill_top", 32'(top_data), 1);
    ins_req = 1'b1; ins_data = 8'd0;
    tick();
    ins_req = 1'b0;
    chk("ovf_pulse", 32'(ovf), 1);
    chk("ovf_ready", 32'(ready), 1);
    chk("ovf_count", 32'(count), 255);
    tick();
    chk("ovf_clear", 32'(ovf), 0);
    for (int k = 1; k <= 255; k++) begin
      do_remove(got);
      chk("drain_order", 32'(got), 32'(k));
    end
    chk("drain_empty", 32'(empty), 1);

    // Simultaneous requests: remove wins, insert waits for the next ready cycle.
    do_insert(8'd4); do_insert(8'd6);
    rem_req = 1'b1; ins_req = 1'b1; ins_data = 8'd2;
    tick();
    rem_req = 1'b0;
    chk("both_rem_valid", 32'(rem_valid), 1);
    chk("both_rem_data", 32'(rem_data), 4);
    chk("both_busy", 32'(ready), 0);
    wait_ready();
    chk("both_count1", 32'(count), 1);
    chk("both_top6", 32'(top_data), 6);
    tick();
    ins_req = 1'b0;
    chk("both_ins_busy", 32'(ready), 0);
    wait_ready();
    chk("both_count2", 32'(count), 2);
    chk("both_top2", 32'(top_data), 2);

    // Heap now 2,6,9; remove reaches DN_CMP four edges after acceptance.
    do_insert(8'd9);
    rem_req = 1'b1; tick(); rem_req = 1'b0;
    chk("dn_rem_data", 32'(rem_data), 2);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_rem_valid", 32'(rem_valid), 0);
    do_insert(8'd9);
    chk("post_top9", 32'(top_data), 9);
    chk("post_count", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
